ibuffer_ctrl: RTL and testbench

- Instruction buffer controller between the fetch stage and ctrlblock.
- Queues fetched instruction/PC pairs in a circular FIFO and presents them in program order on the ibuffer_instr_valid / ibuffer_inst_out / ibuffer_pc_out interface consumed by ctrlblock.
- Applies backpressure to fetch.
- Squashes all buffered instructions on a redirect, using a one-cycle flush sequence.

---
 rtl/ibuffer_ctrl_if.sv | 32 +++
 rtl/ibuffer_ctrl.sv | 119 +++++++++++
 tb/tb_ibuffer_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibuffer_ctrl_if.sv
// Fetch -> instruction buffer -> ctrlblock handshake bundle.
// master is the fetch/ctrlblock side, slave is the buffer controller.
interface ibuffer_ctrl_if #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 48
);
  logic                    fetch_valid;
  logic                    fetch_ready;
  logic [INST_WIDTH-1:0]   fetch_inst;
  logic [PC_WIDTH-1:0]     fetch_pc;
  logic                    ibuffer_instr_valid;
  logic [INST_WIDTH-1:0]   ibuffer_inst_out;
  logic [PC_WIDTH-1:0]     ibuffer_pc_out;
  logic                    ibuffer_ready;
  logic                    redirect_valid;
  logic [$clog2(DEPTH):0]  ibuffer_count;
  logic                    ibuffer_full;
  logic                    ibuffer_empty;

  modport master (
    output fetch_valid, fetch_inst, fetch_pc, ibuffer_ready, redirect_valid,
    input  fetch_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
    input  ibuffer_count, ibuffer_full, ibuffer_empty
  );

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, ibuffer_ready, redirect_valid,
    output fetch_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
    output ibuffer_count, ibuffer_full, ibuffer_empty
  );
endinterface

// File: rtl/ibuffer_ctrl.sv
// Instruction buffer: circular FIFO of inst/PC pairs from fetch to ctrlblock; redirect squashes via a 1-cycle FLUSH.
// Latency: 1 cycle push-to-output (0 with IBUFFER_BYPASS_EN when empty).
// Backpressure: fetch_ready drops when full (unless head popped), during redirect, FLUSH and reset.
module ibuffer_ctrl #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 48
) (
  input  logic            clock,
  input  logic            reset,
  ibuffer_ctrl_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state, state_next;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [INST_WIDTH-1:0]  inst_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];

  logic                   empty, full, bypass;
  logic                   push, pop, flush_now;
  logic                   fetch_ready, instr_valid;
  logic [INST_WIDTH-1:0]  inst_out;
  logic [PC_WIDTH-1:0]    pc_out;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef IBUFFER_BYPASS_EN
  // Empty buffer: hand fetch straight to ctrlblock in the same cycle.
  assign bypass = (state == RUN) && empty && bus.fetch_valid && !bus.redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    flush_now   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    fetch_ready = 1'b0;
    instr_valid = 1'b0;
    inst_out    = '0;
    pc_out      = '0;
    case (state)
      RUN: begin
        fetch_ready = !reset && (!full || bus.ibuffer_ready) && !bus.redirect_valid;
        instr_valid = !empty || bypass;
        if (!empty) begin
          inst_out = inst_mem[rd_ptr];
          pc_out   = pc_mem[rd_ptr];
        end else if (bypass) begin
          inst_out = bus.fetch_inst;
          pc_out   = bus.fetch_pc;
        end
        if (bus.redirect_valid) begin
          // Nothing commits on the redirect edge; contents are dropped instead.
          state_next = FLUSH;
          flush_now  = 1'b1;
        end else begin
          pop  = !empty && bus.ibuffer_ready;
          push = bus.fetch_valid && fetch_ready && !(bypass && bus.ibuffer_ready);
        end
      end
      FLUSH: begin
        flush_now  = bus.redirect_valid;
        state_next = bus.redirect_valid ? FLUSH : RUN;
      end
      default: begin
        state_next = RUN;
        flush_now  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Storage needs no reset: outputs are masked to zero while nothing is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.fetch_inst;
      pc_mem[wr_ptr]   <= bus.fetch_pc;
    end
  end

  assign bus.fetch_ready         = fetch_ready;
  assign bus.ibuffer_instr_valid = instr_valid;
  assign bus.ibuffer_inst_out    = inst_out;
  assign bus.ibuffer_pc_out      = pc_out;
  assign bus.ibuffer_count       = count;
  assign bus.ibuffer_full        = full;
  assign bus.ibuffer_empty       = empty;
endmodule

// File: tb/tb_ibuffer_ctrl.sv
// Bench for ibuffer_ctrl: vector table, directed corner sequences, random traffic vs a queue model.
module tb_ibuffer_ctrl;
  localparam int DEPTH = 8;
`ifdef IBUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ibuffer_ctrl_if #(.DEPTH(DEPTH), .INST_WIDTH(32), .PC_WIDTH(48)) b ();

  ibuffer_ctrl #(.DEPTH(DEPTH), .INST_WIDTH(32), .PC_WIDTH(48)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  typedef struct {
    logic [31:0] inst;
    logic [47:0] pc;
  } ent_t;

  typedef struct {
    bit          fv;
    logic [47:0] pc;
    bit          rdy;
    logic [3:0]  cnt;
    bit          vld;
    logic [47:0] pco;
    bit          frdy;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  bit          in_flush = 1'b0;
  logic [47:0] obs[$];
  vec_t        tbl[7];

  function automatic logic [31:0] inst_of(input logic [47:0] pc);
    return pc[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle's inputs just after the falling edge, then let them settle.
  task automatic step(input bit fv, input logic [47:0] pc, input bit rdy, input bit rd);
    b.fetch_valid    = fv;
    b.fetch_pc       = pc;
    b.fetch_inst     = inst_of(pc);
    b.ibuffer_ready  = rdy;
    b.redirect_valid = rd;
    #2;
  endtask

  // Compare against the queue model, advance the model by one clock, move to the next falling edge.
  task automatic tick();
    int          n;
    bit          byp, e_ready, e_valid;
    logic [47:0] e_pc;
    logic [31:0] e_inst;
    n       = mq.size();
    byp     = BYP && !in_flush && n == 0 && b.fetch_valid && !b.redirect_valid;
    e_ready = !in_flush && (n < DEPTH || b.ibuffer_ready) && !b.redirect_valid;
    e_valid = !in_flush && (n > 0 || byp);
    e_pc    = (n > 0) ? mq[0].pc   : (byp ? b.fetch_pc   : 48'h0);
    e_inst  = (n > 0) ? mq[0].inst : (byp ? b.fetch_inst : 32'h0);
    chk("model_valid", 64'(b.ibuffer_instr_valid), 64'(e_valid));
    chk("model_pc",    64'(b.ibuffer_pc_out),      64'(e_pc));
    chk("model_inst",  64'(b.ibuffer_inst_out),    64'(e_inst));
    chk("model_fready",64'(b.fetch_ready),         64'(e_ready));
    chk("model_count", 64'(b.ibuffer_count),       64'(n));
    chk("model_full",  64'(b.ibuffer_full),        64'(n == DEPTH));
    chk("model_empty", 64'(b.ibuffer_empty),       64'(n == 0));
    if (b.ibuffer_instr_valid && b.ibuffer_ready && !b.redirect_valid)
      obs.push_back(b.ibuffer_pc_out);
    if (b.redirect_valid) begin
      mq.delete();
      in_flush = 1'b1;
    end else if (in_flush) begin
      in_flush = 1'b0;
    end else begin
      if (e_valid && b.ibuffer_ready && n > 0) void'(mq.pop_front());
      if (b.fetch_valid && e_ready && !(byp && b.ibuffer_ready))
        mq.push_back('{inst: b.fetch_inst, pc: b.fetch_pc});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    tbl[0] = '{1'b1, 48'h1000, 1'b0, 4'd0, BYP,  (BYP ? 48'h1000 : 48'h0), 1'b1};
    tbl[1] = '{1'b1, 48'h1004, 1'b0, 4'd1, 1'b1, 48'h1000, 1'b1};
    tbl[2] = '{1'b1, 48'h1008, 1'b0, 4'd2, 1'b1, 48'h1000, 1'b1};
    tbl[3] = '{1'b0, 48'h0,    1'b1, 4'd3, 1'b1, 48'h1000, 1'b1};
    tbl[4] = '{1'b0, 48'h0,    1'b1, 4'd2, 1'b1, 48'h1004, 1'b1};
    tbl[5] = '{1'b0, 48'h0,    1'b1, 4'd1, 1'b1, 48'h1008, 1'b1};
    tbl[6] = '{1'b0, 48'h0,    1'b0, 4'd0, 1'b0, 48'h0,    1'b1};

    b.fetch_valid = 1'b0; b.fetch_pc = '0; b.fetch_inst = '0;
    b.ibuffer_ready = 1'b0; b.redirect_valid = 1'b0;
    #2;
    chk("rst_valid",  64'(b.ibuffer_instr_valid), 64'd0);
    chk("rst_count",  64'(b.ibuffer_count),       64'd0);
    chk("rst_empty",  64'(b.ibuffer_empty),       64'd1);
    chk("rst_full",   64'(b.ibuffer_full),        64'd0);
    chk("rst_fready", 64'(b.fetch_ready),         64'd0);
    chk("rst_pc",     64'(b.ibuffer_pc_out),      64'd0);
    @(negedge clock);
    reset = 1'b0;

    // In-order drain of three entries.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].fv, tbl[i].pc, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_count", i),  64'(b.ibuffer_count),       64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i),  64'(b.ibuffer_instr_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i),     64'(b.ibuffer_pc_out),      64'(tbl[i].pco));
      chk($sformatf("tbl%0d_fready", i), 64'(b.fetch_ready),         64'(tbl[i].frdy));
      tick();
    end

    // Fill to full, hold a 9th fetch, then push+pop at full.
    obs.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 48'h1100 + 48'(4 * i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 48'h1120, 1'b0, 1'b0);
      chk("full_flag",   64'(b.ibuffer_full),  64'd1);
      chk("full_fready", 64'(b.fetch_ready),   64'd0);
      chk("full_count",  64'(b.ibuffer_count), 64'd8);
      tick();
    end
    step(1'b1, 48'h1120, 1'b1, 1'b0);
    chk("full_pp_fready", 64'(b.fetch_ready),    64'd1);
    chk("full_pp_head",   64'(b.ibuffer_pc_out), 64'h1100);
    tick();
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("full_pp_count", 64'(b.ibuffer_count),  64'd8);
    chk("full_pp_head2", 64'(b.ibuffer_pc_out), 64'h1104);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 48'h0, 1'b1, 1'b0);
      tick();
    end
    chk("full_drain_n", 64'(obs.size()), 64'd9);
    if (obs.size() == 9) chk("held_9th_last", 64'(obs[8]), 64'h1120);

    // Wrap: 20 instructions with ready toggling every cycle.
    obs.delete();
    begin
      int sent = 0;
      for (int c = 0; c < 120 && obs.size() < 20; c++) begin
        bit acc;
        step(sent < 20, 48'h4000 + 48'(4 * sent), c[0], 1'b0);
        acc = (sent < 20) && b.fetch_ready;
        tick();
        if (acc) sent++;
      end
    end
    chk("wrap_n", 64'(obs.size()), 64'd20);
    for (int i = 0; i < obs.size() && i < 20; i++)
      chk($sformatf("wrap_pc%0d", i), 64'(obs[i]), 64'h4000 + 64'(4 * i));

    // Redirect with five entries, then a fresh stream.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 48'h1200 + 48'(4 * i), 1'b0, 1'b0);
      tick();
    end
    step(1'b0, 48'h0, 1'b0, 1'b1);
    tick();
    step(1'b1, 48'h2000, 1'b0, 1'b0);
    chk("flush_valid",  64'(b.ibuffer_instr_valid), 64'd0);
    chk("flush_fready", 64'(b.fetch_ready),         64'd0);
    chk("flush_count",  64'(b.ibuffer_count),       64'd0);
    tick();
    step(1'b1, 48'h2000, 1'b0, 1'b0);
    chk("post_flush_fready", 64'(b.fetch_ready), 64'd1);
    tick();
    step(1'b0, 48'h0, 1'b1, 1'b0);
    chk("post_flush_head", 64'(b.ibuffer_pc_out),      64'h2000);
    chk("post_flush_vld",  64'(b.ibuffer_instr_valid), 64'd1);
    tick();

    // Redirect held two cycles stretches FLUSH.
    step(1'b1, 48'h2100, 1'b0, 1'b0); tick();
    step(1'b0, 48'h0, 1'b0, 1'b1);    tick();
    step(1'b0, 48'h0, 1'b0, 1'b1);
    chk("flush2_fready_a", 64'(b.fetch_ready), 64'd0);
    tick();
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("flush2_fready_b", 64'(b.fetch_ready), 64'd0);
    tick();
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("flush2_fready_c", 64'(b.fetch_ready), 64'd1);
    tick();

    // Asynchronous reset mid-stream with four entries.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 48'h1300 + 48'(4 * i), 1'b0, 1'b0);
      tick();
    end
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("pre_arst_valid", 64'(b.ibuffer_instr_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid",  64'(b.ibuffer_instr_valid), 64'd0);
    chk("arst_count",  64'(b.ibuffer_count),       64'd0);
    chk("arst_pc",     64'(b.ibuffer_pc_out),      64'd0);
    chk("arst_inst",   64'(b.ibuffer_inst_out),    64'd0);
    chk("arst_fready", 64'(b.fetch_ready),         64'd0);
    mq.delete();
    in_flush = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("post_arst_empty",  64'(b.ibuffer_empty), 64'd1);
    chk("post_arst_fready", 64'(b.fetch_ready),   64'd1);
    tick();

    // Empty buffer with fetch and ready both high.
    step(1'b1, 48'h3000, 1'b1, 1'b0);
`ifdef IBUFFER_BYPASS_EN
    chk("byp_valid", 64'(b.ibuffer_instr_valid), 64'd1);
    chk("byp_pc",    64'(b.ibuffer_pc_out),      64'h3000);
    tick();
    step(1'b0, 48'h0, 1'b0, 1'b0);
    chk("byp_count", 64'(b.ibuffer_count), 64'd0);
    tick();
`else
    chk("nobyp_valid0", 64'(b.ibuffer_instr_valid), 64'd0);
    tick();
    step(1'b0, 48'h0, 1'b1, 1'b0);
    chk("nobyp_valid1", 64'(b.ibuffer_instr_valid), 64'd1);
    chk("nobyp_pc1",    64'(b.ibuffer_pc_out),      64'h3000);
    tick();
`endif

    // Random traffic; fetch holds an offered instruction until it is taken.
    begin
      bit          hold = 1'b0;
      logic [47:0] rpc  = 48'h8000;
      for (int c = 0; c < 600; c++) begin
        bit fv, rdy, rd;
        rd  = ($urandom_range(0, 15) == 0);
        fv  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        step(fv, rpc, rdy, rd);
        if (fv && b.fetch_ready) begin
          rpc  = rpc + 48'd4;
          hold = 1'b0;
        end else begin
          hold = fv && !rd;
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
